bram_wr_sched: RTL and testbench
================================

Name: bram_wr_sched

Overview:
- Write-port scheduler for the 8-bank BRAM array: arbitrates between two write requesters (A: serial byte loader, B: fill/clear engine).
- Sequences each accepted write through setup / strobe / hold phases on the shared write address, data and per-bank strobe outputs.
- Sits between the loaders and the bramN_wr_addr / wr_data / strobe fan-out. The video read path is untouched.

Parameters:
- SETUP_CYC, 1, cycles address/data are stable before the strobe rises (legal range 1..15)
- STROBE_CYC, 2, cycles the bank strobe is held high (1..15)
- HOLD_CYC, 2, cycles address/data are held after the strobe falls (1..15)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- a_valid  in  1  requester A has a write pending
- a_addr  in  13  A write address; [12:10] selects the bank, [9:0] is the word address
- a_data  in  8  A write byte
- a_ready  out  1  A request accepted this cycle
- b_valid, b_addr, b_data, b_ready  same as for A
- hold_off  in  1  when high, no new grant is issued
- wr_addr  out  10  shared BRAM write word address
- wr_data  out  8  shared BRAM write byte
- wr_strobe  out  8  one-hot bank write strobe
- busy  out  1  a write sequence is in progress
- grant_b  out  1  0 = current/last grant went to A, 1 = to B
- done  out  1  one-cycle pulse in the last HOLD cycle

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous, active-high. Reset clears:
  - wr_addr, wr_data, wr_strobe, busy, grant_b, done to 0
  - state to IDLE
  - round-robin pointer so that A has priority
  - phase counter to 0
- Reset mid-sequence: any strobe drops immediately (asynchronously) and the pending write is discarded.
- States: IDLE, SETUP, STROBE, HOLD.
- IDLE:
  - If hold_off=0 and any valid is high, grant exactly one requester.
  - a_ready/b_ready are combinational and high only in IDLE, for the winner, with hold_off=0. The transfer happens on valid&&ready.
  - On the transfer edge: latch wr_addr <= addr[9:0], wr_data <= data, and an internal 3-bit bank <= addr[12:10]. Set busy=1, set grant_b to the winner, go to SETUP, and load the counter.
- Arbitration:
  - Only one requester valid: that one wins.
  - Both valid: the winner is the one not granted last time (round-robin).
  - After reset, A wins a tie.
- SETUP: wr_strobe=0 for SETUP_CYC cycles, then STROBE.
- STROBE: wr_strobe = 1<<bank for STROBE_CYC cycles, then HOLD. Exactly one strobe bit is ever high.
- HOLD:
  - wr_strobe=0 for HOLD_CYC cycles; done=1 in the final HOLD cycle.
  - Then return to IDLE with busy=0. wr_addr and wr_data keep their last values.
- Outputs: all registered. wr_addr and wr_data are constant from SETUP through HOLD.
- Throughput: one write per 1+SETUP_CYC+STROBE_CYC+HOLD_CYC cycles (6 at defaults).
  - IDLE is always visited for at least one cycle between writes.
  - The earliest next grant is the cycle after the last HOLD cycle.
- hold_off:
  - Sampled only in IDLE.
  - Asserting it during SETUP/STROBE/HOLD does not abort the in-flight write.
  - While it is high, requests stay pending and ready stays 0.
- Valid deasserted by a requester before acceptance: no write occurs (requesters are not required to hold valid, but valid&&ready is the only transfer).
- Addresses are passed through without modification; no wrap or increment is performed here.

Test Plan:
- Single A write, addr=13'h0C05, data=8'h5A, defaults:
  - a_ready pulses 1 cycle; wr_addr=10'h005, wr_data=8'h5A.
  - wr_strobe=8'h08 for exactly 2 cycles, starting 2 cycles after accept.
  - done pulses 5 cycles after accept; busy high for 5 cycles.
- A and B valid continuously with distinct addresses:
  - grants alternate A,B,A,B.
  - each write spans 6 cycles; strobes never overlap.
  - the bank follows each request's addr[12:10].
- hold_off=1 with a_valid=1 for 20 cycles:
  - no ready, no strobe, busy=0.
  - drop hold_off: accept on the next cycle.
  - hold_off raised during STROBE: the write completes normally.
- reset asserted during STROBE (bank 7):
  - wr_strobe goes to 8'h00 without waiting for a clock edge.
  - all outputs are 0 after reset.
  - the next simultaneous A/B request grants A.
- SETUP_CYC=3, STROBE_CYC=1, HOLD_CYC=4:
  - strobe high 1 cycle at accept+4.
  - done at accept+8; next grant no earlier than accept+9.
- a_valid pulsed for 1 cycle while busy:
  - no write is produced, and the pulse is not remembered.

Source files
------------

// File: rtl/bram_wr_sched.sv
// Write-port scheduler for the 8-bank BRAM array: round-robin grant between a
// byte loader (A) and a fill/clear engine (B), then setup / strobe / hold sequencing.
module bram_wr_sched #(
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 2,
  parameter int unsigned HOLD_CYC   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_valid,
  input  logic [12:0] a_addr,
  input  logic [7:0]  a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [12:0] b_addr,
  input  logic [7:0]  b_data,
  output logic        b_ready,
  input  logic        hold_off,
  output logic [9:0]  wr_addr,
  output logic [7:0]  wr_data,
  output logic [7:0]  wr_strobe,
  output logic        busy,
  output logic        grant_b,
  output logic        done
);

  localparam int unsigned WORD_W = 10;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned BANKS  = 8;
  localparam int unsigned BANK_W = 3;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [BANK_W-1:0]   bank_q;
  logic                prio_b_q;
  logic [WORD_W-1:0]   wr_addr_q;
  logic [DATA_W-1:0]   wr_data_q;
  logic [BANKS-1:0]    wr_strobe_q;
  logic                busy_q;
  logic                grant_b_q;
  logic                done_q;

  logic                can_grant;
  logic                win_b;
  logic                accept;
  logic [12:0]         sel_addr;
  logic [DATA_W-1:0]   sel_data;

  // Grant window and round-robin winner; prio_b_q=1 means B wins a tie.
  always_comb begin
    can_grant = (state_q == IDLE) && !hold_off;
    win_b     = b_valid && (!a_valid || prio_b_q);
    a_ready   = can_grant && a_valid && !win_b;
    b_ready   = can_grant && win_b;
    accept    = a_ready || b_ready;
    sel_addr  = win_b ? b_addr : a_addr;
    sel_data  = win_b ? b_data : a_data;
  end

  // Sequencer: every phase length is counted down from (cycles-1) to 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bank_q      <= '0;
      prio_b_q    <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_strobe_q <= '0;
      busy_q      <= 1'b0;
      grant_b_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            state_q   <= SETUP;
            cnt_q     <= CNT_W'(SETUP_CYC - 1);
            wr_addr_q <= sel_addr[WORD_W-1:0];
            wr_data_q <= sel_data;
            bank_q    <= sel_addr[12:10];
            busy_q    <= 1'b1;
            grant_b_q <= win_b;
            prio_b_q  <= !win_b;
          end
        end
        SETUP: begin
          if (cnt_q == '0) begin
            state_q     <= STROBE;
            cnt_q       <= CNT_W'(STROBE_CYC - 1);
            wr_strobe_q <= BANKS'(1) << bank_q;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        STROBE: begin
          if (cnt_q == '0) begin
            state_q     <= HOLD;
            cnt_q       <= CNT_W'(HOLD_CYC - 1);
            wr_strobe_q <= '0;
            done_q      <= (HOLD_CYC == 1);
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        HOLD: begin
          if (cnt_q == '0) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q  <= cnt_q - CNT_W'(1);
            done_q <= (cnt_q == CNT_W'(1));
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign wr_strobe = wr_strobe_q;
  assign busy      = busy_q;
  assign grant_b   = grant_b_q;
  assign done      = done_q;

endmodule

// File: tb/tb_bram_wr_sched.sv
// Bench for bram_wr_sched: default-timing and 3/1/4-timing instances, checked against
// a cycle-offset model of each accepted write plus a strobe-triggered scoreboard.
module tb_bram_wr_sched;

  typedef struct {
    int         rise;
    logic [2:0] bank;
    logic [9:0] addr;
    logic [7:0] data;
    bit         is_b;
  } txn_t;

  logic        clk = 1'b0;
  logic        reset    [2];
  logic        a_valid  [2];
  logic        b_valid  [2];
  logic        hold_off [2];
  logic [12:0] a_addr   [2];
  logic [12:0] b_addr   [2];
  logic [7:0]  a_data   [2];
  logic [7:0]  b_data   [2];
  logic        a_ready  [2];
  logic        b_ready  [2];
  logic [9:0]  wr_addr  [2];
  logic [7:0]  wr_data  [2];
  logic [7:0]  wr_strobe[2];
  logic        busy     [2];
  logic        grant_b  [2];
  logic        done     [2];

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  txn_t sbq0[$];
  txn_t sbq1[$];

  int         c0      [2];
  bit         prio_b  [2];
  logic [9:0] e_addr  [2];
  logic [7:0] e_data  [2];
  logic [2:0] e_bank  [2];
  bit         e_grant [2];
  bit         in_strobe[2];
  logic [7:0] prev_str[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bram_wr_sched u_dut0 (
    .clk(clk), .reset(reset[0]),
    .a_valid(a_valid[0]), .a_addr(a_addr[0]), .a_data(a_data[0]), .a_ready(a_ready[0]),
    .b_valid(b_valid[0]), .b_addr(b_addr[0]), .b_data(b_data[0]), .b_ready(b_ready[0]),
    .hold_off(hold_off[0]), .wr_addr(wr_addr[0]), .wr_data(wr_data[0]),
    .wr_strobe(wr_strobe[0]), .busy(busy[0]), .grant_b(grant_b[0]), .done(done[0])
  );

  bram_wr_sched #(.SETUP_CYC(3), .STROBE_CYC(1), .HOLD_CYC(4)) u_dut1 (
    .clk(clk), .reset(reset[1]),
    .a_valid(a_valid[1]), .a_addr(a_addr[1]), .a_data(a_data[1]), .a_ready(a_ready[1]),
    .b_valid(b_valid[1]), .b_addr(b_addr[1]), .b_data(b_data[1]), .b_ready(b_ready[1]),
    .hold_off(hold_off[1]), .wr_addr(wr_addr[1]), .wr_data(wr_data[1]),
    .wr_strobe(wr_strobe[1]), .busy(busy[1]), .grant_b(grant_b[1]), .done(done[1])
  );

  function automatic int s_of(int g); return (g == 0) ? 1 : 3; endfunction
  function automatic int t_of(int g); return (g == 0) ? 2 : 1; endfunction
  function automatic int h_of(int g); return (g == 0) ? 2 : 4; endfunction

  function automatic string nm(int g, string s);
    return $sformatf("%s[%0d]", s, g);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference: each write is a window of offsets after its accept cycle.
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      int S, T, H, k;
      logic [7:0] es;
      bit eb, ed, acc, wb;
      txn_t t;
      S = s_of(g); T = t_of(g); H = h_of(g);
      if (reset[g]) begin
        c0[g] = -1000; prio_b[g] = 1'b0; e_addr[g] = '0; e_data[g] = '0;
        e_bank[g] = '0; e_grant[g] = 1'b0; in_strobe[g] = 1'b0;
        if (g == 0) sbq0.delete(); else sbq1.delete();
        chk(nm(g, "rst_busy"), 32'(busy[g]), 32'd0);
        chk(nm(g, "rst_strobe"), 32'(wr_strobe[g]), 32'd0);
        chk(nm(g, "rst_done"), 32'(done[g]), 32'd0);
        chk(nm(g, "rst_grant_b"), 32'(grant_b[g]), 32'd0);
        chk(nm(g, "rst_wr_addr"), 32'(wr_addr[g]), 32'd0);
        chk(nm(g, "rst_wr_data"), 32'(wr_data[g]), 32'd0);
      end else begin
        k  = cyc - c0[g];
        eb = (k >= 1) && (k <= S + T + H);
        es = (k > S && k <= S + T) ? (8'h01 << e_bank[g]) : 8'h00;
        ed = (k == S + T + H);
        in_strobe[g] = (es != 8'h00);
        chk(nm(g, "busy"), 32'(busy[g]), 32'(eb));
        chk(nm(g, "strobe"), 32'(wr_strobe[g]), 32'(es));
        chk(nm(g, "done"), 32'(done[g]), 32'(ed));
        chk(nm(g, "grant_b"), 32'(grant_b[g]), 32'(e_grant[g]));
        chk(nm(g, "wr_addr"), 32'(wr_addr[g]), 32'(e_addr[g]));
        chk(nm(g, "wr_data"), 32'(wr_data[g]), 32'(e_data[g]));
        acc = 1'b0; wb = 1'b0;
        if (!eb && !hold_off[g] && (a_valid[g] || b_valid[g])) begin
          acc = 1'b1;
          wb  = b_valid[g] && (!a_valid[g] || prio_b[g]);
        end
        chk(nm(g, "a_ready"), 32'(a_ready[g]), 32'(acc && !wb));
        chk(nm(g, "b_ready"), 32'(b_ready[g]), 32'(acc && wb));
        if (acc) begin
          c0[g]      = cyc;
          prio_b[g]  = !wb;
          e_grant[g] = wb;
          e_addr[g]  = wb ? b_addr[g][9:0] : a_addr[g][9:0];
          e_data[g]  = wb ? b_data[g] : a_data[g];
          e_bank[g]  = wb ? b_addr[g][12:10] : a_addr[g][12:10];
          t.rise = cyc + S + 1; t.bank = e_bank[g]; t.addr = e_addr[g];
          t.data = e_data[g]; t.is_b = wb;
          if (g == 0) sbq0.push_back(t); else sbq1.push_back(t);
        end
      end
    end
  end

  // Scoreboard monitor: every rising strobe must match the oldest accepted write.
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      txn_t t;
      bit have;
      if (reset[g]) begin
        prev_str[g] = 8'h00;
      end else begin
        if (wr_strobe[g] != 8'h00 && prev_str[g] == 8'h00) begin
          have = (g == 0) ? (sbq0.size() > 0) : (sbq1.size() > 0);
          chk(nm(g, "sb_expected_write"), 32'(have), 32'd1);
          if (have) begin
            if (g == 0) t = sbq0.pop_front(); else t = sbq1.pop_front();
            chk(nm(g, "sb_rise_cycle"), 32'(cyc), 32'(t.rise));
            chk(nm(g, "sb_bank"), 32'(wr_strobe[g]), 32'(8'h01 << t.bank));
            chk(nm(g, "sb_addr"), 32'(wr_addr[g]), 32'(t.addr));
            chk(nm(g, "sb_data"), 32'(wr_data[g]), 32'(t.data));
            chk(nm(g, "sb_grant_b"), 32'(grant_b[g]), 32'(t.is_b));
          end
        end
        prev_str[g] = wr_strobe[g];
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic wait_strobe0(output bit found);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (in_strobe[0]) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    bit found;
    for (int g = 0; g < 2; g++) begin
      reset[g] = 1'b1; a_valid[g] = 1'b0; b_valid[g] = 1'b0; hold_off[g] = 1'b0;
      a_addr[g] = '0; b_addr[g] = '0; a_data[g] = '0; b_data[g] = '0;
    end
    idle(3);
    reset[0] = 1'b0; reset[1] = 1'b0;
    idle(2);

    // Single A write on both timings.
    for (int g = 0; g < 2; g++) begin
      a_addr[g] = 13'h0C05; a_data[g] = 8'h5A; a_valid[g] = 1'b1;
    end
    @(negedge clk); #1;
    chk("single_a_ready", 32'(a_ready[0]), 32'd1);
    step();
    a_valid[0] = 1'b0; a_valid[1] = 1'b0;
    @(negedge clk); #1;
    @(negedge clk); #1;
    chk("single_strobe_bank3", 32'(wr_strobe[0]), 32'h08);
    idle(12);

    // Both requesters valid continuously: alternating grants.
    repeat (40) begin
      for (int g = 0; g < 2; g++) begin
        a_valid[g] = 1'b1; b_valid[g] = 1'b1;
        a_addr[g] = 13'($urandom); b_addr[g] = 13'($urandom);
        a_data[g] = 8'($urandom);  b_data[g] = 8'($urandom);
      end
      step();
    end
    for (int g = 0; g < 2; g++) begin a_valid[g] = 1'b0; b_valid[g] = 1'b0; end
    idle(12);

    // hold_off blocks a pending request; dropping it grants next cycle.
    hold_off[0] = 1'b1; a_valid[0] = 1'b1; a_addr[0] = 13'h0A11; a_data[0] = 8'hC3;
    idle(20);
    hold_off[0] = 1'b0;
    @(negedge clk); #1;
    chk("accept_after_holdoff", 32'(a_ready[0]), 32'd1);
    step();
    a_valid[0] = 1'b0;
    idle(8);

    // hold_off raised during STROBE does not abort the write.
    b_valid[0] = 1'b1; b_addr[0] = 13'h1234; b_data[0] = 8'h99;
    step();
    b_valid[0] = 1'b0;
    wait_strobe0(found);
    chk("wait_strobe_holdoff", 32'(found), 32'd1);
    step();
    hold_off[0] = 1'b1;
    idle(8);
    hold_off[0] = 1'b0;
    idle(2);

    // One-cycle A pulse while busy is neither accepted nor remembered.
    b_valid[0] = 1'b1; b_addr[0] = 13'h0777; b_data[0] = 8'h11;
    step();
    b_valid[0] = 1'b0;
    idle(2);
    a_valid[0] = 1'b1; a_addr[0] = 13'h1555; a_data[0] = 8'hEE;
    step();
    a_valid[0] = 1'b0;
    idle(12);

    // Reset during a bank-7 strobe drops it without a clock edge.
    a_valid[0] = 1'b1; a_addr[0] = 13'h1EA5; a_data[0] = 8'h3C;
    step();
    a_valid[0] = 1'b0;
    wait_strobe0(found);
    chk("wait_strobe_reset", 32'(found), 32'd1);
    chk("pre_reset_strobe", 32'(wr_strobe[0]), 32'h80);
    reset[0] = 1'b1;
    #1;
    chk("async_strobe_drop", 32'(wr_strobe[0]), 32'd0);
    chk("async_busy_drop", 32'(busy[0]), 32'd0);
    idle(2);
    reset[0] = 1'b0;
    a_valid[0] = 1'b1; b_valid[0] = 1'b1;
    a_addr[0] = 13'h0101; b_addr[0] = 13'h0202;
    @(negedge clk); #1;
    chk("post_reset_tie_a", 32'(a_ready[0]), 32'd1);
    chk("post_reset_tie_not_b", 32'(b_ready[0]), 32'd0);
    step();
    a_valid[0] = 1'b0; b_valid[0] = 1'b0;
    idle(10);

    // Randomized traffic on both instances.
    repeat (400) begin
      for (int g = 0; g < 2; g++) begin
        a_valid[g]  = ($urandom_range(0, 2) == 0);
        b_valid[g]  = ($urandom_range(0, 2) == 0);
        hold_off[g] = ($urandom_range(0, 9) == 0);
        a_addr[g] = 13'($urandom); b_addr[g] = 13'($urandom);
        a_data[g] = 8'($urandom);  b_data[g] = 8'($urandom);
      end
      step();
    end
    for (int g = 0; g < 2; g++) begin
      a_valid[g] = 1'b0; b_valid[g] = 1'b0; hold_off[g] = 1'b0;
    end
    idle(15);
    chk("sb_drained[0]", 32'(sbq0.size()), 32'd0);
    chk("sb_drained[1]", 32'(sbq1.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
